// File: rtl/beam_power_rd.sv
// Ping-pong capture of per-RBG beam power sums, streamed out one beam per beat.
// Optional BEAM_PWR_RD_MAXSEL_EN adds a per-RBG argmax of the saturated beam powers.
module beam_power_rd #(
    parameter int BEAM    = 16,
    parameter int IW      = 40,
    parameter int OW      = 32,
    parameter int SHIFT   = 8,
    parameter int RBG_MAX = 132
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [BEAM*IW-1:0]       i_wr_sum,
    input  logic [7:0]               i_wr_addr,
    input  logic                     i_wr_wen,
    input  logic                     i_wr_sop,
    input  logic                     i_wr_eos,
    output logic [OW-1:0]            o_pwr,
    output logic [$clog2(BEAM)-1:0]  o_beam_idx,
    output logic [7:0]               o_rbg_idx,
    output logic                     o_vld,
    input  logic                     i_rdy,
    output logic                     o_sop,
    output logic                     o_eop,
    output logic                     o_rbg_last,
    output logic [$clog2(BEAM)-1:0]  o_max_beam,
    output logic                     o_ovf
);

    localparam int BW = $clog2(BEAM);
    localparam logic [8:0] RBG_LIM = 9'(RBG_MAX);
    localparam logic [BW-1:0] BEAM_LAST = BW'(BEAM - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_LOAD, S_SHIFT} state_t;

    state_t state_q, state_d;

    logic [BEAM*IW-1:0] mem_q [2][RBG_MAX];
    logic [BEAM*IW-1:0] rd_data_q;

    logic wr_bank_q, rd_bank_q, ovf_q;
    logic [8:0] wr_cnt_q, rd_cnt_q;
    logic [7:0] rbg_q, rbg_d;
    logic [BW-1:0] beam_q, beam_d;
    logic [BEAM-1:0][OW-1:0] row_q, row_d;
    logic [BEAM-1:0][OW-1:0] sat_v;

    logic wen_ok, eos_hit, start;
    logic [8:0] addr_p1, cnt_base, cnt_new, rbg_nxt;

    function automatic logic [OW-1:0] sat(input logic [IW-1:0] s);
        logic [IW-1:0] t;
        t = s >> SHIFT;
        if ((t >> OW) != '0) sat = '1;
        else                 sat = t[OW-1:0];
    endfunction

    // Write-side RBG count: highest accepted address + 1 since sop/eos
    always_comb begin
        wen_ok   = i_wr_wen && ({1'b0, i_wr_addr} < RBG_LIM);
        addr_p1  = {1'b0, i_wr_addr} + 9'd1;
        cnt_base = i_wr_sop ? 9'd0 : wr_cnt_q;
        cnt_new  = (wen_ok && addr_p1 > cnt_base) ? addr_p1 : cnt_base;
        eos_hit  = i_wr_eos && (cnt_new != 9'd0);
        start    = eos_hit && (state_q == S_IDLE);
        rbg_nxt  = {1'b0, rbg_q} + 9'd1;
    end

    always_ff @(posedge i_clk) begin
        if (wen_ok) mem_q[wr_bank_q][i_wr_addr] <= i_wr_sum;
        rd_data_q <= mem_q[rd_bank_q][rbg_q];
    end

    always_comb begin
        for (int b = 0; b < BEAM; b++)
            sat_v[b] = sat(rd_data_q[b*IW +: IW]);
    end

    always_comb begin
        state_d = state_q;
        rbg_d   = rbg_q;
        beam_d  = beam_q;
        row_d   = row_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    rbg_d   = '0;
                    beam_d  = '0;
                end
            end
            S_REQ: state_d = S_LOAD;
            S_LOAD: begin
                state_d = S_SHIFT;
                beam_d  = '0;
                row_d   = sat_v;
            end
            S_SHIFT: begin
                if (i_rdy) begin
                    if (beam_q == BEAM_LAST) begin
                        beam_d = '0;
                        if (rbg_nxt < rd_cnt_q) begin
                            rbg_d   = rbg_nxt[7:0];
                            state_d = S_REQ;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        beam_d = beam_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            rbg_q     <= '0;
            beam_q    <= '0;
            row_q     <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rbg_q    <= rbg_d;
            beam_q   <= beam_d;
            row_q    <= row_d;
            wr_cnt_q <= i_wr_eos ? 9'd0 : cnt_new;
            // A busy reader drops the whole symbol; the write bank is reused
            if (eos_hit) begin
                if (state_q == S_IDLE) begin
                    rd_bank_q <= wr_bank_q;
                    wr_bank_q <= ~wr_bank_q;
                    rd_cnt_q  <= cnt_new;
                end else begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

`ifdef BEAM_PWR_RD_MAXSEL_EN
    logic [BW-1:0] max_q, max_v;
    logic [OW-1:0] best;

    // Strict compare keeps the lowest index on ties
    always_comb begin
        max_v = '0;
        best  = sat_v[0];
        for (int b = 1; b < BEAM; b++) begin
            if (sat_v[b] > best) begin
                best  = sat_v[b];
                max_v = BW'(b);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)                max_q <= '0;
        else if (state_q == S_LOAD) max_q <= max_v;
    end

    assign o_max_beam = max_q;
`else
    assign o_max_beam = '0;
`endif

    assign o_vld      = (state_q == S_SHIFT);
    assign o_pwr      = row_q[beam_q];
    assign o_beam_idx = beam_q;
    assign o_rbg_idx  = rbg_q;
    assign o_sop      = o_vld && (beam_q == '0) && (rbg_q == '0);
    assign o_rbg_last = o_vld && (beam_q == BEAM_LAST);
    assign o_eop      = o_rbg_last && (rbg_nxt == rd_cnt_q);
    assign o_ovf      = ovf_q;

endmodule

// File: tb/tb_beam_power_rd.sv
// Directed bench for beam_power_rd: streaming, saturation, backpressure,
// overflow, ignored writes/eos, sop restart and mid-read reset.
module tb_beam_power_rd;

    localparam int BEAM = 16;
    localparam int IW   = 40;
    localparam int OW   = 32;

`ifdef BEAM_PWR_RD_MAXSEL_EN
    localparam bit MAXSEL = 1'b1;
`else
    localparam bit MAXSEL = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [BEAM*IW-1:0] i_wr_sum = '0;
    logic [7:0]         i_wr_addr = '0;
    logic               i_wr_wen = 1'b0;
    logic               i_wr_sop = 1'b0;
    logic               i_wr_eos = 1'b0;
    logic               i_rdy = 1'b0;
    logic [OW-1:0]      o_pwr;
    logic [3:0]         o_beam_idx;
    logic [7:0]         o_rbg_idx;
    logic               o_vld, o_sop, o_eop, o_rbg_last, o_ovf;
    logic [3:0]         o_max_beam;

    int errors = 0;
    int checks = 0;

    logic [31:0]        exp_pwr [0:63];
    logic [3:0]         exp_max [0:3];
    logic [BEAM*IW-1:0] row_v;

    beam_power_rd dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_wr_sum   (i_wr_sum),
        .i_wr_addr  (i_wr_addr),
        .i_wr_wen   (i_wr_wen),
        .i_wr_sop   (i_wr_sop),
        .i_wr_eos   (i_wr_eos),
        .o_pwr      (o_pwr),
        .o_beam_idx (o_beam_idx),
        .o_rbg_idx  (o_rbg_idx),
        .o_vld      (o_vld),
        .i_rdy      (i_rdy),
        .o_sop      (o_sop),
        .o_eop      (o_eop),
        .o_rbg_last (o_rbg_last),
        .o_max_beam (o_max_beam),
        .o_ovf      (o_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_ramp(input int base);
        for (int b = 0; b < BEAM; b++)
            row_v[b*IW +: IW] = 40'(base + b) << 8;
    endtask

    task automatic wr(input logic [7:0] a, input bit sop);
        i_wr_wen  = 1'b1;
        i_wr_addr = a;
        i_wr_sum  = row_v;
        i_wr_sop  = sop;
        @(negedge clk);
        i_wr_wen  = 1'b0;
        i_wr_sop  = 1'b0;
    endtask

    task automatic eos();
        i_wr_eos = 1'b1;
        @(negedge clk);
        i_wr_eos = 1'b0;
    endtask

    task automatic write_sym(input int base, input int n);
        for (int r = 0; r < n; r++) begin
            fill_ramp(base + r * BEAM);
            wr(8'(r), 1'b0);
        end
    endtask

    task automatic set_exp_ramp(input int base, input int n);
        for (int k = 0; k < n * BEAM; k++) exp_pwr[k] = 32'(base + k);
        for (int r = 0; r < n; r++) exp_max[r] = MAXSEL ? 4'd15 : 4'd0;
    endtask

    task automatic read_sym(input int nrbg, input bit rnd);
        int k, cyc, last, total;
        bit r;
        k = 0; cyc = 0; last = 0; total = nrbg * BEAM;
        while (k < total && cyc < 3000) begin
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (o_vld) begin
                chk("pwr", o_pwr, exp_pwr[k]);
                chk("beam_idx", o_beam_idx, 64'(k % BEAM));
                chk("rbg_idx", o_rbg_idx, 64'(k / BEAM));
                chk("sop", o_sop, k == 0);
                chk("eop", o_eop, k == total - 1);
                chk("rbg_last", o_rbg_last, (k % BEAM) == BEAM - 1);
                chk("max_beam", o_max_beam, exp_max[k / BEAM]);
                if (!rnd && k > 0 && (k % BEAM) == 0)
                    chk("bubble", 64'(cyc - last), 64'd3);
                if (r) begin
                    last = cyc;
                    k++;
                end
            end
            i_rdy = r;
            @(negedge clk);
            cyc++;
        end
        chk("beat_count", 64'(k), 64'(total));
    endtask

    task automatic idle_watch(input int n, input string tag);
        int seen;
        seen = 0;
        repeat (n) begin
            @(negedge clk);
            if (o_vld) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pwr"}, o_pwr, 0);
        chk({tag, "_beam"}, o_beam_idx, 0);
        chk({tag, "_rbg"}, o_rbg_idx, 0);
        chk({tag, "_vld"}, o_vld, 0);
        chk({tag, "_sop"}, o_sop, 0);
        chk({tag, "_eop"}, o_eop, 0);
        chk({tag, "_last"}, o_rbg_last, 0);
        chk({tag, "_max"}, o_max_beam, 0);
        chk({tag, "_ovf"}, o_ovf, 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #3 chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Ramp symbol, 3 RBGs, gapless beats with 2-cycle bubbles
        i_rdy = 1'b1;
        write_sym(0, 3);
        set_exp_ramp(0, 3);
        i_wr_eos = 1'b1;
        @(negedge clk);
        i_wr_eos = 1'b0;
        chk("vld_n1", o_vld, 0);
        @(negedge clk);
        chk("vld_n2", o_vld, 0);
        @(negedge clk);
        chk("vld_n3", o_vld, 1);
        read_sym(3, 1'b0);
        chk("idle_after_sym", o_vld, 0);

        // Saturation and max-beam tie
        row_v = '0;
        row_v[0 +: IW]  = '1;
        row_v[IW +: IW] = 40'h12345600;
        wr(8'd0, 1'b0);
        for (int b = 0; b < BEAM; b++) row_v[b*IW +: IW] = 40'(b) << 8;
        row_v[5*IW +: IW] = 40'd1000 << 8;
        row_v[9*IW +: IW] = 40'd1000 << 8;
        wr(8'd1, 1'b0);
        for (int k = 0; k < 32; k++) exp_pwr[k] = 32'd0;
        exp_pwr[0] = 32'hFFFF_FFFF;
        exp_pwr[1] = 32'h0012_3456;
        for (int b = 0; b < BEAM; b++) exp_pwr[16 + b] = 32'(b);
        exp_pwr[21] = 32'd1000;
        exp_pwr[25] = 32'd1000;
        exp_max[0] = 4'd0;
        exp_max[1] = MAXSEL ? 4'd5 : 4'd0;
        eos();
        read_sym(2, 1'b0);

        // Random backpressure
        write_sym(0, 3);
        set_exp_ramp(0, 3);
        eos();
        read_sym(3, 1'b1);
        chk("ovf_clear", o_ovf, 0);

        // Overflow: second symbol arrives while first is stalled in readout
        i_rdy = 1'b0;
        write_sym(100, 3);
        eos();
        repeat (4) @(negedge clk);
        chk("stalled_vld", o_vld, 1);
        fill_ramp(900);
        wr(8'd0, 1'b0);
        eos();
        chk("ovf_set", o_ovf, 1);
        set_exp_ramp(100, 3);
        read_sym(3, 1'b0);
        idle_watch(10, "no_dropped_beats");

        // Out-of-range write and empty eos produce nothing
        fill_ramp(50);
        wr(8'd200, 1'b0);
        eos();
        eos();
        idle_watch(10, "ignored_eos");

        // sop restarts the RBG count at the same-cycle write
        fill_ramp(7);
        wr(8'd5, 1'b0);
        fill_ramp(300);
        wr(8'd0, 1'b1);
        eos();
        set_exp_ramp(300, 1);
        read_sym(1, 1'b0);
        idle_watch(5, "sop_restart_len");
        chk("ovf_sticky", o_ovf, 1);

        // Reset mid-readout
        i_rdy = 1'b1;
        write_sym(200, 2);
        eos();
        repeat (6) @(negedge clk);
        chk("pre_reset_vld", o_vld, 1);
        #2 rst = 1'b1;
        #1 chk_zero("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        write_sym(400, 2);
        set_exp_ramp(400, 2);
        eos();
        read_sym(2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
